pll_reset_seq: RTL and testbench

Reset sequencer on the consumer side of the main PLL. It takes the PLL `locked` output, debounces it, and releases a clean reset to the logic clocked by the PLL only after lock has been stable for a programmed time. It re-asserts that reset on any loss of lock and counts the losses. It runs on the free-running 25 MHz board clock that feeds the PLL, never on a PLL output, so it keeps working while the PLL is unlocked.

---
 rtl/pll_reset_seq.sv | 160 ++++++++++++++++
 tb/tb_pll_reset_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL consumer-side reset sequencer: debounces pll_locked, releases sys_reset after a stable period.
// Optional PLL reset-request timeout is compiled in with PLL_RESET_SEQ_TIMEOUT_EN.
module pll_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             sys_reset,
  output logic             sys_ready,
  output logic             pll_rst,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       seq_state
);

  // state     | meaning
  // WAIT_LOCK | waiting for synchronized lock
  // STABLE    | lock seen, counting debounce period
  // HOLD      | debounce done, holding sys_reset a little longer
  // RUN       | downstream released
  // PLL_RST   | timeout expired, requesting PLL reset
  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABLE    = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] PLL_RST   = 3'd4;

  localparam int MAX_SR   = (STABLE_CYCLES > RESET_HOLD) ? STABLE_CYCLES : RESET_HOLD;
  localparam int MAX_ALL  = (MAX_SR > TIMEOUT_CYCLES) ? MAX_SR : TIMEOUT_CYCLES;
  localparam int CNT_BITS = $clog2(MAX_ALL) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             state, state_nxt;
  logic [CNT_BITS-1:0]    cnt, cnt_nxt;
  logic                   loss_inc;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  logic [CNT_BITS-1:0] tcnt, tcnt_nxt;
  logic                waiting;
  assign waiting = (state == WAIT_LOCK) || (state == STABLE) || (state == HOLD);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_inc  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_BITS'(STABLE_CYCLES - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_BITS'(RESET_HOLD)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_inc  = 1'b1;
        end
      end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
      PLL_RST: begin
        if (cnt == CNT_BITS'(3)) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
`else
      PLL_RST: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
`endif
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    // Timeout overrides lock progress; the return edge from PLL_RST counts as the first waiting cycle.
    tcnt_nxt = '0;
    if (waiting && tcnt == CNT_BITS'(TIMEOUT_CYCLES)) begin
      state_nxt = PLL_RST;
      cnt_nxt   = '0;
    end else if (state != RUN &&
                 (state_nxt == WAIT_LOCK || state_nxt == STABLE || state_nxt == HOLD)) begin
      tcnt_nxt = tcnt + CNT_BITS'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      loss_count <= '0;
      sys_reset  <= 1'b1;
      sys_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_reset <= (state_nxt != RUN);
      sys_ready <= (state_nxt == RUN);
      if (loss_inc && loss_count != '1) loss_count <= loss_count + CNT_W'(1);
    end
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= '0;
      pll_rst <= 1'b0;
    end else begin
      tcnt    <= tcnt_nxt;
      pll_rst <= (state_nxt == PLL_RST);
    end
  end
`else
  assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: release/loss latency, debounce glitches, saturation, reset, timeout.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset, sys_ready, pll_rst;
  logic [7:0] loss_count;
  logic [2:0] seq_state;
  logic       sat_sys_reset, sat_sys_ready, sat_pll_rst;
  logic [1:0] sat_loss_count;
  logic [2:0] sat_seq_state;

  int tests  = 0;
  int failed = 0;

  always #20 clk = ~clk;

  pll_reset_seq #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .RESET_HOLD(4),
                  .TIMEOUT_CYCLES(64), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .sys_reset(sys_reset), .sys_ready(sys_ready), .pll_rst(pll_rst),
    .loss_count(loss_count), .seq_state(seq_state));

  pll_reset_seq #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .RESET_HOLD(4),
                  .TIMEOUT_CYCLES(64), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .sys_reset(sat_sys_reset), .sys_ready(sat_sys_ready), .pll_rst(sat_pll_rst),
    .loss_count(sat_loss_count), .seq_state(sat_seq_state));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_released(input string tag);
    check({tag, "_sys_reset"}, 32'(sys_reset), 32'd0);
    check({tag, "_sys_ready"}, 32'(sys_ready), 32'd1);
    check({tag, "_state"},     32'(seq_state), 32'd3);
  endtask

  initial begin
    int  exp_sat;
    logic seen_rst;

    // reset values
    reset = 1'b1; pll_locked = 1'b0;
    tick(3);
    check("rst_sys_reset",  32'(sys_reset),  32'd1);
    check("rst_sys_ready",  32'(sys_ready),  32'd0);
    check("rst_pll_rst",    32'(pll_rst),    32'd0);
    check("rst_loss_count", 32'(loss_count), 32'd0);
    check("rst_state",      32'(seq_state),  32'd0);

    // clean lock: release at cycle 15 exactly
    reset = 1'b0; pll_locked = 1'b1;
    tick(15);
    check("clean_c14_sys_reset", 32'(sys_reset), 32'd1);
    check("clean_c14_state",     32'(seq_state), 32'd2);
    tick(1);
    check_released("clean_c15");
    check("clean_loss", 32'(loss_count), 32'd0);

    // loss in RUN: visible two edges after the dropped sample
    tick(5);
    pll_locked = 1'b0;
    tick(2);
    check("loss_k1_ready", 32'(sys_ready), 32'd1);
    tick(1);
    check("loss_k2_sys_reset", 32'(sys_reset),     32'd1);
    check("loss_k2_ready",     32'(sys_ready),     32'd0);
    check("loss_k2_count",     32'(loss_count),    32'd1);
    check("loss_k2_state",     32'(seq_state),     32'd0);
    check("loss_k2_sat_count", 32'(sat_loss_count), 32'd1);
    pll_locked = 1'b1;
    tick(15);
    check("relock_c14_sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    check_released("relock_c15");

    // synchronous reset in RUN: no loss counted
    reset = 1'b1;
    tick(1);
    check("midrun_sys_reset", 32'(sys_reset),  32'd1);
    check("midrun_ready",     32'(sys_ready),  32'd0);
    check("midrun_loss",      32'(loss_count), 32'd0);
    check("midrun_state",     32'(seq_state),  32'd0);
    reset = 1'b0;
    tick(15);
    check("midrun_c14_sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    check_released("midrun_c15");

    // glitch during STABLE: sampled low at cycle 6, release at 22
    reset = 1'b1; pll_locked = 1'b0;
    tick(2);
    reset = 1'b0; pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    check("glitch_c8_state", 32'(seq_state), 32'd0);
    tick(13);
    check("glitch_c21_sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    check_released("glitch_c22");
    check("glitch_loss", 32'(loss_count), 32'd0);

    // drop arriving exactly at the HOLD terminal count wins over RUN
    reset = 1'b1; pll_locked = 1'b0;
    tick(2);
    reset = 1'b0; pll_locked = 1'b1;
    tick(13);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("holdterm_c14_state", 32'(seq_state), 32'd2);
    tick(1);
    check("holdterm_c15_state",     32'(seq_state), 32'd0);
    check("holdterm_c15_sys_reset", 32'(sys_reset), 32'd1);
    check("holdterm_c15_ready",     32'(sys_ready), 32'd0);
    tick(13);
    check("holdterm_c28_sys_reset", 32'(sys_reset), 32'd1);
    tick(1);
    check_released("holdterm_c29");
    check("holdterm_loss", 32'(loss_count), 32'd0);

    // five losses: wide counter counts, 2-bit counter saturates at 3
    for (int n = 1; n <= 5; n++) begin
      pll_locked = 1'b0;
      tick(3);
      exp_sat = (n > 3) ? 3 : n;
      check($sformatf("sat_loss%0d_wide", n), 32'(loss_count), 32'(n));
      check($sformatf("sat_loss%0d_narrow", n), 32'(sat_loss_count), 32'(exp_sat));
      pll_locked = 1'b1;
      tick(16);
      check($sformatf("sat_loss%0d_ready", n), 32'(sys_ready), 32'd1);
    end

    // timeout behaviour with lock held low
    reset = 1'b1; pll_locked = 1'b0;
    tick(2);
    reset = 1'b0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    tick(64);
    check("to_c63_pll_rst", 32'(pll_rst), 32'd0);
    tick(1);
    check("to_c64_pll_rst",   32'(pll_rst),   32'd1);
    check("to_c64_state",     32'(seq_state), 32'd4);
    check("to_c64_sys_reset", 32'(sys_reset), 32'd1);
    tick(3);
    check("to_c67_pll_rst", 32'(pll_rst), 32'd1);
    tick(1);
    check("to_c68_pll_rst", 32'(pll_rst),   32'd0);
    check("to_c68_state",   32'(seq_state), 32'd0);
    tick(63);
    check("to_c131_pll_rst", 32'(pll_rst), 32'd0);
    tick(1);
    check("to_c132_pll_rst", 32'(pll_rst), 32'd1);
`else
    seen_rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (pll_rst !== 1'b0) seen_rst = 1'b1;
    end
    check("noto_pll_rst_seen", 32'(seen_rst),  32'd0);
    check("noto_state",        32'(seq_state), 32'd0);
    check("noto_sys_reset",    32'(sys_reset), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
